mul_job_arbiter: RTL and testbench
==================================

Name: mul_job_arbiter

Overview:
Scheduler and sequencer for the shared 24x24 shift-add multiplier and ones-counter datapath. Two requesters submit operand pairs over valid/ready handshakes. A round-robin arbiter grants one job at a time and runs the multiplier one operand bit per clock, then the popcount stage. It returns a tagged result (low product word, ones count, overflow flag) on a back-pressurable response port, and keeps a completed-job counter.

Parameters:
OPW, 24, operand width in bits; product width is 2*OPW
RESW, 32, result word width taken from the product LSBs; must satisfy RESW <= 2*OPW
CNTW, 16, width of the completed-operation counter
(derived) ONW = $clog2(RESW+1), width of the ones count (6 at default)

Ports:
clk  in  1  system clock, all logic on rising edge
n_reset  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle
req0_a1  in  OPW  requester 0 multiplicand
req0_a2  in  OPW  requester 0 multiplier
req1_valid / req1_ready / req1_a1 / req1_a2  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester index of the job
rsp_w  out  RESW  product[RESW-1:0]
rsp_ones  out  ONW  number of 1 bits in rsp_w
rsp_ovf  out  1  product[2*OPW-1:RESW] nonzero
busy  out  1  state != IDLE
op_count  out  CNTW  completed (handshaken) responses, wraps

Behaviour:
- Reset: synchronous, checked before every other action, including mid-job. State goes to IDLE and any in-flight job is discarded.
- Reset values: rsp_valid=0, rsp_id=0, rsp_w=0, rsp_ones=0, rsp_ovf=0, op_count=0, busy=0, reqN_ready=0. last_grant resets to 1, so requester 0 wins the first tie.
- reqN_ready is combinational: (state==IDLE) & reqN_valid & (grant==N). It is never 1 for both requesters in the same cycle.
- Grant rule:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester != last_grant.
- Requesters must hold their operands stable while valid & !ready. Operands are captured only on the handshake cycle.
- State machine:
  - IDLE: on a handshake, latch a1 and a2, set id and last_grant, clear acc and bit index i, go to MULT.
  - MULT: lasts exactly OPW cycles. Each cycle, if a2[i], then acc += a1 << i (acc is 2*OPW bits, no truncation), and i increments. The cycle with i==OPW-1 transitions to COUNT.
  - COUNT: one cycle. Register rsp_w=acc[RESW-1:0], rsp_ones=popcount(acc[RESW-1:0]), rsp_ovf=|acc[2*OPW-1:RESW] (0 when RESW==2*OPW), rsp_id. Go to RESP.
  - RESP: rsp_valid=1, with all rsp_* held stable until rsp_ready. On rsp_valid & rsp_ready, op_count increments (modulo 2^CNTW), rsp_valid drops next cycle, and the state goes to IDLE.
- Latency: a handshake at edge T gives rsp_valid high from cycle T+OPW+2 (26 at default).
- Minimum job spacing is OPW+3 cycles, since IDLE always costs at least one cycle.
- No requests are accepted outside IDLE, including while stalled in RESP.
- rsp_* fields keep their last values after the handshake until the next COUNT overwrites them. They are valid only while rsp_valid is high.
- Operand corner cases: a1=0 or a2=0 gives w=0, ones=0, ovf=0. Full-scale operands must not lose carries.

Test Plan:
- Reset, then req0 with a1=3, a2=5 -> req0_ready pulses for 1 cycle; 26 cycles later rsp_valid=1 with rsp_w=0x0000000F, rsp_ones=4, rsp_ovf=0, rsp_id=0; after rsp_ready, op_count=1.
- req1 with a1=a2=0xFFFFFF -> product 0xFFFFFE000001, so rsp_w=0xFE000001, rsp_ones=8, rsp_ovf=1, rsp_id=1.
- req0_valid and req1_valid held high with rsp_ready=1 -> grants alternate 0,1,0,1 (first grant to 0 after reset); rsp_id sequence 0,1,0,1; op_count=4; ready never asserted to both requesters in one cycle.
- Hold rsp_ready=0 for 10 cycles in RESP with both requesters valid -> rsp_* stable, reqN_ready stays 0, op_count unchanged; raise rsp_ready -> op_count+1, and the next grant occurs in the cycle after returning to IDLE.
- Assert n_reset=0 for one cycle mid-MULT -> next cycle busy=0, rsp_valid=0, op_count=0; no response ever issues for the aborted job; a subsequent tie is granted to requester 0.
- CNTW=2: complete 5 jobs of a1=1, a2=1 -> op_count sequence 1,2,3,0,1 (wrap); each response has rsp_w=1, rsp_ones=1.

Source files
------------

// File: rtl/mul_job_arbiter.sv
// Two-requester round-robin scheduler in front of a bit-serial shift-add multiplier
// with a popcount stage and a back-pressurable tagged response port.
module mul_job_arbiter #(
    parameter int OPW  = 24,
    parameter int RESW = 32,
    parameter int CNTW = 16,
    localparam int ONW = $clog2(RESW + 1)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_a1,
    input  logic [OPW-1:0]  req0_a2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_a1,
    input  logic [OPW-1:0]  req1_a2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_w,
    output logic [ONW-1:0]  rsp_ones,
    output logic            rsp_ovf,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    // state | meaning
    // IDLE  | waiting for a request; only state in which jobs are accepted
    // MULT  | one multiplier bit per cycle, OPW cycles
    // COUNT | register low word, ones count and overflow flag
    // RESP  | hold response until rsp_ready
    typedef enum logic [1:0] {IDLE, MULT, COUNT, RESP} state_t;

    localparam int PW = 2 * OPW;
    localparam int IW = (OPW > 1) ? $clog2(OPW) : 1;

    state_t          state, state_next;
    logic [OPW-1:0]  a1, a2;
    logic [PW-1:0]   acc;
    logic [IW-1:0]   i;
    logic            id;
    logic            last_grant;
    logic            grant;
    logic            take;
    logic            last_bit;
    logic            ovf;

    function automatic logic [ONW-1:0] popcount(input logic [RESW-1:0] v);
        logic [ONW-1:0] c;
        c = '0;
        for (int k = 0; k < RESW; k++) c = c + ONW'(v[k]);
        return c;
    endfunction

    generate
        if (RESW < PW) begin : g_ovf
            assign ovf = |acc[PW-1:RESW];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign take       = req0_ready || req1_ready;
    assign last_bit   = (i == IW'(OPW - 1));
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = MULT;
            MULT:    if (last_bit) state_next = COUNT;
            COUNT:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            a1         <= '0;
            a2         <= '0;
            acc        <= '0;
            i          <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_w      <= '0;
            rsp_ones   <= '0;
            rsp_ovf    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a1         <= grant ? req1_a1 : req0_a1;
                        a2         <= grant ? req1_a2 : req0_a2;
                        id         <= grant;
                        last_grant <= grant;
                        acc        <= '0;
                        i          <= '0;
                    end
                end
                MULT: begin
                    if (a2[i]) acc <= acc + (PW'(a1) << i);
                    i <= i + 1'b1;
                end
                COUNT: begin
                    rsp_w    <= acc[RESW-1:0];
                    rsp_ones <= popcount(acc[RESW-1:0]);
                    rsp_ovf  <= ovf;
                    rsp_id   <= id;
                end
                RESP: begin
                    if (rsp_ready) op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_job_arbiter.sv
// Randomized scoreboard bench for mul_job_arbiter; a second instance with a 2-bit
// counter shares all stimulus to exercise counter wrap.
module tb_mul_job_arbiter;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [23:0] req0_a1 = '0, req0_a2 = '0, req1_a1 = '0, req1_a2 = '0;
    logic        rsp_ready = 1'b0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf, busy;
    logic [31:0] rsp_w;
    logic [5:0]  rsp_ones;
    logic [15:0] op_count;
    logic        b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_ovf, b_busy;
    logic [31:0] b_rsp_w;
    logic [5:0]  b_rsp_ones;
    logic [1:0]  b_op_count;

    mul_job_arbiter dut (
        .clk(clk), .n_reset(n_reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a1(req0_a1), .req0_a2(req0_a2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a1(req1_a1), .req1_a2(req1_a2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_w(rsp_w),
        .rsp_ones(rsp_ones), .rsp_ovf(rsp_ovf), .busy(busy), .op_count(op_count)
    );

    mul_job_arbiter #(.CNTW(2)) dut_w (
        .clk(clk), .n_reset(n_reset),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a1(req0_a1), .req0_a2(req0_a2),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a1(req1_a1), .req1_a2(req1_a2),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_w(b_rsp_w),
        .rsp_ones(b_rsp_ones), .rsp_ovf(b_rsp_ovf), .busy(b_busy), .op_count(b_op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [31:0] w;
        int          ones;
        bit          ovf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   rsp_mode = 0;
    bit   free = 1'b1;
    bit   last = 1'b1;
    int   count = 0;
    int   cyc = 0, acc_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [23:0] a, input logic [23:0] b);
        exp_t   e;
        longint p;
        p      = longint'(a) * longint'(b);
        e.id   = id;
        e.w    = p[31:0];
        e.ones = $countones(p[31:0]);
        e.ovf  = (p >> 32) != 0;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: model of the arbiter/sequencer at job granularity.
    always @(negedge clk) begin
        bit   g, e0, e1;
        exp_t e;
        cyc++;
        if (!n_reset) begin
            free  = 1'b1;
            last  = 1'b1;
            count = 0;
            q.delete();
        end else begin
            g = 1'b0;
            if (req0_valid && req1_valid) g = ~last;
            else if (req1_valid)          g = 1'b1;
            e0 = free && req0_valid && !g;
            e1 = free && req1_valid && g;
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("both_ready", req0_ready && req1_ready, 0);
            chk("busy", busy, !free);
            chk("op_count", op_count, count % 65536);
            chk("op_count_wrap", b_op_count, count % 4);
            chk("rsp_valid", rsp_valid, !free && (cyc - acc_cyc >= 26));
            chk("wrap_rsp_valid", b_rsp_valid, rsp_valid);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = q[0];
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_w", rsp_w, e.w);
                    chk("rsp_ones", rsp_ones, e.ones);
                    chk("rsp_ovf", rsp_ovf, e.ovf);
                    chk("wrap_rsp_w", b_rsp_w, e.w);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        count++;
                        free = 1'b1;
                    end
                end
            end
            if (e0 || e1) begin
                q.push_back(model(g, g ? req1_a1 : req0_a1, g ? req1_a2 : req0_a2));
                free    = 1'b0;
                last    = g;
                acc_cyc = cyc;
            end
        end
    end

    task automatic submit(input bit id, input logic [23:0] a, input logic [23:0] b);
        bit ok;
        if (!id) begin req0_a1 = a; req0_a2 = b; req0_valid = 1'b1; end
        else     begin req1_a1 = a; req1_a2 = b; req1_valid = 1'b1; end
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input bit id);
        if (!id) req0_valid = 1'b0;
        else     req1_valid = 1'b0;
    endtask

    function automatic logic [23:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 24'h0;
            1:       return 24'hFFFFFF;
            default: return 24'($urandom());
        endcase
    endfunction

    task automatic stream(input bit id, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            submit(id, rand_op(), rand_op());
            if (gaps && $urandom_range(0, 1) == 1) begin
                drop(id);
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
            end
        end
        drop(id);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        @(negedge clk);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_w", rsp_w, 0);
        chk("reset_rsp_ones", rsp_ones, 0);
        chk("reset_rsp_ovf", rsp_ovf, 0);
        @(posedge clk);
        #1;

        submit(0, 24'd3, 24'd5);
        drop(0);
        submit(1, 24'hFFFFFF, 24'hFFFFFF);
        drop(1);

        fork
            stream(0, 2, 1'b0);
            stream(1, 2, 1'b0);
        join

        rsp_mode = 2;
        fork
            begin submit(0, rand_op(), rand_op()); drop(0); end
            begin submit(1, rand_op(), rand_op()); drop(1); end
            begin repeat (60) @(posedge clk); #1 rsp_mode = 0; end
        join

        submit(0, 24'($urandom()), 24'($urandom()));
        drop(0);
        repeat (10) @(posedge clk);
        #1 n_reset = 1'b0;
        @(posedge clk);
        #1 n_reset = 1'b1;
        fork
            begin submit(0, rand_op(), rand_op()); drop(0); end
            begin submit(1, rand_op(), rand_op()); drop(1); end
        join

        rsp_mode = 1;
        fork
            stream(0, 15, 1'b1);
            stream(1, 15, 1'b1);
        join

        rsp_mode = 0;
        for (int k = 0; k < 5; k++) begin
            submit(0, 24'd1, 24'd1);
            drop(0);
        end

        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            done = (q.size() == 0) && free;
        end
        if (!done) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
